// File: rtl/time_set_clock.sv
// -----------------------------------------------------------------------------
// time_set_clock
//   Hour/minute/second timekeeper with a two-button set mode.
//   One button steps the mode (run -> set seconds -> set minutes -> set hours),
//   the other increments the field the current mode selects. In run mode a
//   prescaler divides clk down to a one-second tick that advances the time
//   with full carry; in the set modes the prescaler is held and time is frozen.
//
// Parameters
//   TICK_DIV           clk cycles per one-second tick (>= 1, 1 = every cycle)
//
// Ports
//   clk                in   1  sole clock, rising edge
//   our_reset          in   1  asynchronous, active-high reset
//   counter_trigger    in   1  async button, rising edge advances the mode
//   increment_trigger  in   1  async button, rising edge bumps selected field
//   mode               out  2  0 run, 1 set sec, 2 set min, 3 set hours
//   seconds            out  6  0..59 binary
//   minutes            out  6  0..59 binary
//   hours              out  5  0..23 binary
//   sec_tick           out  1  registered one-cycle pulse, high in the cycle
//                              the time shows the value the tick produced
// -----------------------------------------------------------------------------
module time_set_clock #(
  parameter int unsigned TICK_DIV = 32768
) (
  input  logic       clk,
  input  logic       our_reset,
  input  logic       counter_trigger,
  input  logic       increment_trigger,
  output logic [1:0] mode,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_SEC = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_HR  = 2'd3
  } mode_e;

  // A prescaler for TICK_DIV = 1 still needs one bit; it simply stays at 0.
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0/1 are the two-flop synchronizer, bit 2 is the
  // edge register. A pulse lasts one cycle no matter how long the button is
  // held, and the state it drives changes on the third edge that saw it high.
  // ---------------------------------------------------------------------------
  logic [2:0] cnt_sync_q, cnt_sync_d;
  logic [2:0] inc_sync_q, inc_sync_d;
  logic       cnt_pulse;
  logic       inc_pulse;

  assign cnt_sync_d = {cnt_sync_q[1:0], counter_trigger};
  assign inc_sync_d = {inc_sync_q[1:0], increment_trigger};
  assign cnt_pulse  = cnt_sync_q[1] & ~cnt_sync_q[2];
  assign inc_pulse  = inc_sync_q[1] & ~inc_sync_q[2];

  // ---------------------------------------------------------------------------
  // Mode FSM: state register / next-state / output decode
  // ---------------------------------------------------------------------------
  mode_e mode_q, mode_d;

  logic run_en;
  logic set_sec_inc;
  logic set_min_inc;
  logic set_hr_inc;

  // Mode wraps 3 -> 0 naturally in two bits.
  assign mode_d = cnt_pulse ? mode_e'(mode_q + 2'd1) : mode_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so a
    // missed branch cannot leave it holding its old value (a latch).
    run_en      = 1'b0;
    set_sec_inc = 1'b0;
    set_min_inc = 1'b0;
    set_hr_inc  = 1'b0;
    unique case (mode_q)
      MODE_RUN:     run_en      = 1'b1;
      MODE_SET_SEC: set_sec_inc = inc_pulse;
      MODE_SET_MIN: set_min_inc = inc_pulse;
      MODE_SET_HR:  set_hr_inc  = inc_pulse;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler: runs only in run mode. Any mode change (including entering run
  // mode) clears it, so the first second after setting is a full second.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = run_en && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (!run_en || tick || cnt_pulse) begin
      presc_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Time fields. The run tick and the set increments are mutually exclusive
  // because they are decoded from different modes. Set increments wrap their
  // own field only; the run tick carries through all three.
  // ---------------------------------------------------------------------------
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q,  hr_d;
  logic       sec_tick_q;

  logic [5:0] sec_inc;
  logic [5:0] min_inc;
  logic [4:0] hr_inc;

  assign sec_inc = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
  assign min_inc = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
  assign hr_inc  = (hr_q  == HR_MAX)  ? 5'd0 : hr_q  + 5'd1;

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick) begin
      sec_d = sec_inc;
      if (sec_q == SEC_MAX) begin
        min_d = min_inc;
        if (min_q == MIN_MAX) begin
          hr_d = hr_inc;
        end
      end
    end else begin
      if (set_sec_inc) sec_d = sec_inc;
      if (set_min_inc) min_d = min_inc;
      if (set_hr_inc)  hr_d  = hr_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge our_reset) begin
    if (our_reset) begin
      cnt_sync_q <= '0;
      inc_sync_q <= '0;
      mode_q     <= MODE_RUN;
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      cnt_sync_q <= cnt_sync_d;
      inc_sync_q <= inc_sync_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= tick;
    end
  end

  assign mode     = mode_q;
  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hr_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_set_clock.sv
// -----------------------------------------------------------------------------
// tb_time_set_clock
//   Two instances share clock, reset and buttons: dut_a ticks every cycle,
//   dut_b ticks every 50 cycles so set-mode sequences finish well inside one
//   second. A behavioural model per instance tracks time as seconds-of-day
//   and is compared on every falling edge; directed checks cover the named
//   scenarios and a randomized phase mixes presses, idling and resets.
// -----------------------------------------------------------------------------
module tb_time_set_clock;

  localparam int DIV_A = 1;
  localparam int DIV_B = 50;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic our_reset = 1'b0;
  logic counter_trigger = 1'b0;
  logic increment_trigger = 1'b0;

  logic [1:0] mode_a, mode_b;
  logic [5:0] seconds_a, seconds_b;
  logic [5:0] minutes_a, minutes_b;
  logic [4:0] hours_a, hours_b;
  logic       sec_tick_a, sec_tick_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 if (clk_run) clk = ~clk;

  time_set_clock #(.TICK_DIV(DIV_A)) dut_a (
    .clk               (clk),
    .our_reset         (our_reset),
    .counter_trigger   (counter_trigger),
    .increment_trigger (increment_trigger),
    .mode              (mode_a),
    .seconds           (seconds_a),
    .minutes           (minutes_a),
    .hours             (hours_a),
    .sec_tick          (sec_tick_a)
  );

  time_set_clock #(.TICK_DIV(DIV_B)) dut_b (
    .clk               (clk),
    .our_reset         (our_reset),
    .counter_trigger   (counter_trigger),
    .increment_trigger (increment_trigger),
    .mode              (mode_b),
    .seconds           (seconds_b),
    .minutes           (minutes_b),
    .hours             (hours_b),
    .sec_tick          (sec_tick_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int       mode;
    int       h;
    int       m;
    int       s;
    int       run_cycles;   // clk cycles spent in run mode since the last second
    bit       tick;         // a second was applied at the most recent edge
    bit [2:0] inc_seen;     // button samples at the last three edges, bit 0 newest
    bit [2:0] cnt_seen;
  } mstate_t;

  function automatic mstate_t model_zero();
    mstate_t z;
    z.mode = 0; z.h = 0; z.m = 0; z.s = 0; z.run_cycles = 0; z.tick = 1'b0;
    z.inc_seen = '0; z.cnt_seen = '0;
    return z;
  endfunction

  // A button press acts on the edge two after the first edge that saw it high.
  function automatic mstate_t model_next(mstate_t c, bit inc_in, bit cnt_in, int div);
    mstate_t n = c;
    bit inc_ev = c.inc_seen[1] && !c.inc_seen[2];
    bit cnt_ev = c.cnt_seen[1] && !c.cnt_seen[2];
    int t;
    n.tick = (c.mode == 0) && (c.run_cycles + 1 == div);
    if (n.tick) begin
      t   = (c.h * 3600 + c.m * 60 + c.s + 1) % 86400;
      n.h = t / 3600;
      n.m = (t / 60) % 60;
      n.s = t % 60;
    end else if (inc_ev) begin
      if (c.mode == 1) n.s = (c.s + 1) % 60;
      if (c.mode == 2) n.m = (c.m + 1) % 60;
      if (c.mode == 3) n.h = (c.h + 1) % 24;
    end
    n.run_cycles = (c.mode == 0 && !n.tick) ? c.run_cycles + 1 : 0;
    if (cnt_ev) begin
      n.mode       = (c.mode + 1) % 4;
      n.run_cycles = 0;
    end
    n.inc_seen = {c.inc_seen[1:0], inc_in};
    n.cnt_seen = {c.cnt_seen[1:0], cnt_in};
    return n;
  endfunction

  function automatic logic [31:0] pack_model(mstate_t x);
    return {12'd0, 2'(x.mode), 5'(x.h), 6'(x.m), 6'(x.s), x.tick};
  endfunction

  function automatic logic [31:0] pack_dut(logic [1:0] md, logic [4:0] h, logic [5:0] m,
                                           logic [5:0] s, logic tk);
    return {12'd0, md, h, m, s, tk};
  endfunction

  function automatic logic [31:0] hms(int h, int m, int s);
    return {12'd0, 2'd0, 5'(h), 6'(m), 6'(s), 1'b0};
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or posedge our_reset) begin
    if (our_reset) begin
      ma <= model_zero();
      mb <= model_zero();
    end else begin
      ma <= model_next(ma, increment_trigger, counter_trigger, DIV_A);
      mb <= model_next(mb, increment_trigger, counter_trigger, DIV_B);
    end
  end

  always @(negedge clk) begin
    check("cycle_a", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a), pack_model(ma));
    check("cycle_b", pack_dut(mode_b, hours_b, minutes_b, seconds_b, sec_tick_b), pack_model(mb));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on falling edges only)
  // ---------------------------------------------------------------------------
  task automatic press(input bit do_inc, input bit do_cnt, input int hold, input int gap);
    @(negedge clk);
    if (do_inc) increment_trigger = 1'b1;
    if (do_cnt) counter_trigger   = 1'b1;
    repeat (hold) @(negedge clk);
    increment_trigger = 1'b0;
    counter_trigger   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic inc_btn();
    press(1'b1, 1'b0, 3, 2);
  endtask

  task automatic cnt_btn();
    press(1'b0, 1'b1, 3, 2);
  endtask

  function automatic logic [31:0] time_b();
    return {12'd0, 2'd0, hours_b, minutes_b, seconds_b, 1'b0};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    #2 our_reset = 1'b1;
    #1;
    check("rst_async_a", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a), 32'd0);
    check("rst_async_b", pack_dut(mode_b, hours_b, minutes_b, seconds_b, sec_tick_b), 32'd0);
    @(negedge clk);
    #2 our_reset = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;

    // Reset with the clock stopped.
    #1 our_reset = 1'b1;
    #1;
    check("rst_hold_a", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a), 32'd0);
    check("rst_hold_b", pack_dut(mode_b, hours_b, minutes_b, seconds_b, sec_tick_b), 32'd0);
    #98 our_reset = 1'b0;
    #1;
    check("rst_rel_a", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a), 32'd0);
    check("rst_rel_b", pack_dut(mode_b, hours_b, minutes_b, seconds_b, sec_tick_b), 32'd0);
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    check("run_start_b", pack_dut(mode_b, hours_b, minutes_b, seconds_b, sec_tick_b), 32'd0);

    // Increment ignored in run mode; mode steps to 1.
    inc_btn();
    cnt_btn();
    check("m0_inc_time", time_b(), hms(0, 0, 0));
    check("m0_inc_mode", 32'(mode_b), 32'd1);

    // Set sequence seconds, minutes, hours, back to run.
    inc_btn(); cnt_btn();
    inc_btn(); cnt_btn();
    inc_btn(); cnt_btn();
    check("set_seq_time", time_b(), hms(1, 1, 1));
    check("set_seq_mode", 32'(mode_b), 32'd0);

    // Set-mode wraps without carry.
    cnt_btn();
    repeat (59) inc_btn();
    check("sec_wrap", time_b(), hms(1, 1, 0));
    cnt_btn(); cnt_btn();
    repeat (23) inc_btn();
    check("hr_wrap", time_b(), hms(0, 1, 0));
    check("hr_wrap_mode", 32'(mode_b), 32'd3);

    // Held button and simultaneous buttons.
    cnt_btn();
    cnt_btn();
    press(1'b1, 1'b0, 50, 2);
    check("held_inc", time_b(), hms(0, 1, 1));
    cnt_btn();
    press(1'b1, 1'b1, 3, 2);
    check("both_time", time_b(), hms(0, 2, 1));
    check("both_mode", 32'(mode_b), 32'd3);
    cnt_btn();

    // Run rollover on dut_a: preload 23:59:58 using the model's frozen time.
    cnt_btn();
    n = (58 - ma.s + 60) % 60;
    repeat (n) inc_btn();
    cnt_btn();
    n = (59 - ma.m + 60) % 60;
    repeat (n) inc_btn();
    cnt_btn();
    n = (23 - ma.h + 24) % 24;
    repeat (n) inc_btn();
    check("preload_a", {12'd0, 2'd0, hours_a, minutes_a, seconds_a, 1'b0}, hms(23, 59, 58));
    press(1'b0, 1'b1, 3, 0);
    check("enter_run_a", 32'(mode_a), 32'd0);
    @(negedge clk);
    check("roll_1", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a),
          hms(23, 59, 59) | 32'd1);
    @(negedge clk);
    check("roll_2", pack_dut(mode_a, hours_a, minutes_a, seconds_a, sec_tick_a),
          hms(0, 0, 0) | 32'd1);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(sec_tick_a);
    end
    check("tick_every_cycle", 32'(pulses), 32'd8);

    // Randomized phase.
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      if (r <= 4) begin
        bit bi = 1'($urandom_range(0, 1));
        press(bi, ~bi, $urandom_range(1, 4), $urandom_range(0, 4));
      end else if (r == 5) begin
        press(1'b1, 1'b1, $urandom_range(1, 4), $urandom_range(0, 4));
      end else if (r <= 8) begin
        repeat ($urandom_range(1, 120)) @(negedge clk);
      end else begin
        pulse_reset();
      end
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
